// File: rtl/fpu_instr_issue.sv
// Instruction issue sequencer in front of the FPU decode stage: queues host words, issues them one at a time.
// Latency: a word pushed into an empty queue at edge t is on Instruction after edge t+1; INT 2 cycles, CSR 3, FP 2+wait.
// Backpressure: wr_ready = registered count < DEPTH (no full bypass); FP ops hold issue until fpu_complete or timeout.
//
// Ports:
//   clk, rst_l            clock, synchronous active-low reset
//   wr_valid/wr_instr     host push request and 32-bit word; wr_ready accepts when not full
//   halt_clr              leave HALT and flush the queue (outside HALT it only clears err)
//   fpu_complete          single-cycle FPU result strobe
//   halt_req              decoder halt / illegal-instruction request, highest priority
//   Instruction           word presented to the decoder, 0 when nothing is issued
//   fpu_active            FP op in flight
//   Activation_Signal     one-cycle integer writeback strobe for ADDI/LUI
//   busy, q_count, err    status: not idle, queue occupancy, sticky timeout flag
//   perf_issued/perf_stall  issue and FP-wait cycle counters
//
// Optional feature: define FPU_ISSUE_PERF_CNT_EN to build the perf counters; otherwise they read 0.

module fpu_instr_issue #(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic                     wr_valid,
    input  logic [31:0]              wr_instr,
    output logic                     wr_ready,
    input  logic                     halt_clr,
    input  logic                     fpu_complete,
    input  logic                     halt_req,
    output logic [31:0]              Instruction,
    output logic                     fpu_active,
    output logic                     Activation_Signal,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     err,
    output logic [31:0]              perf_issued,
    output logic [31:0]              perf_stall
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_FP_WAIT,
        S_DRAIN,
        S_HALT
    } state_t;

    typedef enum logic [1:0] {
        CL_INT,
        CL_CSR,
        CL_FP,
        CL_RST
    } cls_t;

    function automatic cls_t classify(input logic [6:0] op);
        cls_t c;
        case (op)
            7'b1010011, 7'b1000011, 7'b1000111,
            7'b1001011, 7'b1001111: c = CL_FP;
            7'b1110011:             c = CL_CSR;
            7'b0010000:             c = CL_RST;
            default:                c = CL_INT;
        endcase
        return c;
    endfunction

    // Only ADDI and LUI produce an integer writeback strobe; other
    // unclassified opcodes issue silently.
    function automatic logic activates(input logic [6:0] op);
        return (op == 7'b0010011) || (op == 7'b0110111);
    endfunction

    state_t          state;
    cls_t            cls_q;
    logic [15:0]     timer;

    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     head;

    logic            do_push;
    logic            do_pop;
    logic            do_flush;
    logic            timeout_hit;

    assign head     = mem[rd_ptr];
    assign wr_ready = (count < CW'(DEPTH));
    assign q_count  = count;
    assign busy     = (state != S_IDLE) || (count != '0);

    assign do_push  = wr_valid && wr_ready;
    assign do_pop   = (state == S_IDLE) && !halt_req && (count != '0);
    // halt_req wins over both flush sources so a halt arriving with an RST
    // word or with halt_clr leaves the queue untouched.
    assign do_flush = !halt_req &&
                      (((state == S_ISSUE) && (cls_q == CL_RST)) ||
                       ((state == S_HALT) && halt_clr));
    // A completion in the final allowed cycle still counts as on time.
    assign timeout_hit = (state == S_FP_WAIT) && !fpu_complete && (timer == TO_LAST);

    // ------------------------------------------------------------------
    // Instruction queue
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (do_flush) begin
            // A push landing in the flush cycle is dropped with the rest.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Issue sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state             <= S_IDLE;
            cls_q             <= CL_INT;
            timer             <= '0;
            Instruction       <= '0;
            fpu_active        <= 1'b0;
            Activation_Signal <= 1'b0;
            err               <= 1'b0;
        end else begin
            Activation_Signal <= 1'b0;

            if (timeout_hit) begin
                err <= 1'b1;
            end else if (halt_clr) begin
                err <= 1'b0;
            end

            if (halt_req) begin
                state       <= S_HALT;
                Instruction <= '0;
                fpu_active  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (do_pop) begin
                            // Strobes are registered here so they line up
                            // with the word during the ISSUE cycle.
                            Instruction       <= head;
                            cls_q             <= classify(head[6:0]);
                            Activation_Signal <= activates(head[6:0]);
                            fpu_active        <= (classify(head[6:0]) == CL_FP);
                            state             <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        timer <= '0;
                        if (cls_q == CL_FP) begin
                            state <= S_FP_WAIT;
                        end else begin
                            Instruction <= '0;
                            state       <= (cls_q == CL_CSR) ? S_DRAIN : S_IDLE;
                        end
                    end
                    S_FP_WAIT: begin
                        if (fpu_complete) begin
                            Instruction <= '0;
                            fpu_active  <= 1'b0;
                            state       <= S_DRAIN;
                        end else if (timer == TO_LAST) begin
                            Instruction <= '0;
                            fpu_active  <= 1'b0;
                            state       <= S_HALT;
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end
                    S_DRAIN: begin
                        state <= S_IDLE;
                    end
                    S_HALT: begin
                        if (halt_clr) begin
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef FPU_ISSUE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (state == S_ISSUE) begin
                perf_issued <= perf_issued + 32'd1;
            end
            if (state == S_FP_WAIT) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`else
    assign perf_issued = 32'h0;
    assign perf_stall  = 32'h0;
`endif

endmodule

// File: tb/tb_fpu_instr_issue.sv
module tb_fpu_instr_issue;

    localparam int DEPTH = 8;
    localparam int TO    = 255;

    localparam logic [31:0] W_ADDI = 32'h00500093;
    localparam logic [31:0] W_FADD = 32'h002081D3;
    localparam logic [31:0] W_FMAD = 32'h00208043;
    localparam logic [31:0] W_RST  = 32'h00000010;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_instr = '0;
    logic        wr_ready;
    logic        halt_clr = 1'b0;
    logic        fpu_complete = 1'b0;
    logic        halt_req = 1'b0;
    logic [31:0] instruction;
    logic        fpu_active;
    logic        activation_signal;
    logic        busy;
    logic [3:0]  q_count;
    logic        err;
    logic [31:0] perf_issued;
    logic [31:0] perf_stall;

    int n_checks = 0;
    int n_fail   = 0;
    int unsigned exp_issued = 0;
    int unsigned exp_stall  = 0;

    always #5 clk = ~clk;

    fpu_instr_issue #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk               (clk),
        .rst_l             (rst_l),
        .wr_valid          (wr_valid),
        .wr_instr          (wr_instr),
        .wr_ready          (wr_ready),
        .halt_clr          (halt_clr),
        .fpu_complete      (fpu_complete),
        .halt_req          (halt_req),
        .Instruction       (instruction),
        .fpu_active        (fpu_active),
        .Activation_Signal (activation_signal),
        .busy              (busy),
        .q_count           (q_count),
        .err               (err),
        .perf_issued       (perf_issued),
        .perf_stall        (perf_stall)
    );

    // Word classes: 0 ADDI, 1 LUI, 2 unclassified INT, 3 CSR, 4 FP
    function automatic logic [31:0] rand_word(input int c);
        logic [6:0]  op;
        logic [24:0] hi;
        int s;
        s  = $urandom_range(0, 4);
        hi = 25'($urandom());
        case (c)
            0: op = 7'b0010011;
            1: op = 7'b0110111;
            2: case (s)
                   0: op = 7'b0110011;
                   1: op = 7'b0000011;
                   2: op = 7'b0100011;
                   3: op = 7'b1100011;
                   default: op = 7'b1101111;
               endcase
            3: op = 7'b1110011;
            default: case (s)
                   0: op = 7'b1010011;
                   1: op = 7'b1000011;
                   2: op = 7'b1000111;
                   3: op = 7'b1001011;
                   default: op = 7'b1001111;
               endcase
        endcase
        return {hi, op};
    endfunction

    task automatic test_reset();
        rst_l = 1'b0; wr_valid = 1'b1; wr_instr = W_ADDI;
        repeat (3) @(negedge clk);
        n_checks++; if (instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", instruction); end
        n_checks++; if ({fpu_active, activation_signal, busy, err} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {fpu_active, activation_signal, busy, err}); end
        n_checks++; if (q_count !== 4'd0) begin n_fail++; $display("FAIL reset_qcount: got %0d want 0", q_count); end
        n_checks++; if ({perf_issued, perf_stall} !== 64'h0) begin n_fail++; $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_issued, perf_stall); end
        wr_valid = 1'b0; rst_l = 1'b1;
        @(negedge clk);
        n_checks++; if ({wr_ready, q_count} !== {1'b1, 4'd0}) begin n_fail++; $display("FAIL reset_release: got rdy=%b cnt=%0d want 1/0", wr_ready, q_count); end
    endtask

    task automatic test_addi();
        wr_valid = 1'b1; wr_instr = W_ADDI;
        @(negedge clk);
        wr_valid = 1'b0;
        n_checks++; if ({instruction, q_count} !== {32'h0, 4'd1}) begin n_fail++; $display("FAIL addi_t: got %h cnt=%0d want 0 cnt=1", instruction, q_count); end
        @(negedge clk);
        n_checks++; if ({instruction, activation_signal, fpu_active} !== {W_ADDI, 1'b1, 1'b0}) begin n_fail++; $display("FAIL addi_issue: got %h act=%b fa=%b want %h act=1 fa=0", instruction, activation_signal, fpu_active, W_ADDI); end
        @(negedge clk);
        n_checks++; if ({instruction, activation_signal, busy} !== {32'h0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL addi_after: got %h act=%b busy=%b want 0/0/0", instruction, activation_signal, busy); end
        exp_issued += 1;
    endtask

    task automatic test_fadd();
        int active_n = 0;
        bit fell = 0, held_bad = 0;
        wr_valid = 1'b1; wr_instr = W_FADD;
        @(negedge clk);
        wr_valid = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (fpu_active) begin
                active_n++;
                if (instruction !== W_FADD) held_bad = 1;
            end else if (active_n > 0) begin
                fell = 1;
                break;
            end
            fpu_complete = (active_n == 6);
        end
        fpu_complete = 1'b0;
        n_checks++; if (!fell || active_n != 6) begin n_fail++; $display("FAIL fadd_active_len: got %0d cycles (ended=%0b) want 6", active_n, fell); end
        n_checks++; if (held_bad) begin n_fail++; $display("FAIL fadd_hold: instruction not held, want %h", W_FADD); end
        n_checks++; if ({instruction, busy} !== {32'h0, 1'b1}) begin n_fail++; $display("FAIL fadd_drain: got %h busy=%b want 0 busy=1", instruction, busy); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fadd_idle: busy=%b want 0", busy); end
        exp_issued += 1; exp_stall += 5;
    endtask

    task automatic test_full();
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            wr_valid = 1'b1; wr_instr = rand_word(0);
            @(negedge clk);
            if (i == DEPTH - 2) begin
                n_checks++; if ({wr_ready, q_count} !== {1'b1, 4'(DEPTH - 1)}) begin n_fail++; $display("FAIL full_almost: rdy=%b cnt=%0d want 1/%0d", wr_ready, q_count, DEPTH - 1); end
            end
            if (i == DEPTH - 1) begin
                n_checks++; if ({wr_ready, q_count} !== {1'b0, 4'(DEPTH)}) begin n_fail++; $display("FAIL full_at_depth: rdy=%b cnt=%0d want 0/%0d", wr_ready, q_count, DEPTH); end
            end
        end
        wr_valid = 1'b0;
        n_checks++; if ({q_count, instruction} !== {4'(DEPTH), 32'h0}) begin n_fail++; $display("FAIL full_overflow: cnt=%0d instr=%h want %0d/0", q_count, instruction, DEPTH); end
        halt_clr = 1'b1;
        @(negedge clk);
        halt_clr = 1'b0;
        n_checks++; if ({q_count, busy} !== {4'd0, 1'b0}) begin n_fail++; $display("FAIL full_clear: cnt=%0d busy=%b want 0/0", q_count, busy); end
    endtask

    task automatic test_timeout();
        int active_n = 0;
        bit fell = 0, err_early = 0;
        wr_valid = 1'b1; wr_instr = W_FMAD;
        @(negedge clk);
        wr_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (fpu_active) begin
                active_n++;
                if (err) err_early = 1;
            end else if (active_n > 0) begin
                fell = 1;
                break;
            end
        end
        n_checks++; if (!fell || active_n != TO + 1) begin n_fail++; $display("FAIL timeout_len: got %0d active cycles (ended=%0b) want %0d", active_n, fell, TO + 1); end
        n_checks++; if (err_early) begin n_fail++; $display("FAIL timeout_early_err: err rose before timeout"); end
        n_checks++; if ({err, busy, instruction} !== {1'b1, 1'b1, 32'h0}) begin n_fail++; $display("FAIL timeout_halt: err=%b busy=%b instr=%h want 1/1/0", err, busy, instruction); end
        wr_valid = 1'b1; wr_instr = W_ADDI;
        @(negedge clk);
        wr_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({q_count, instruction} !== {4'd1, 32'h0}) begin n_fail++; $display("FAIL halt_push: cnt=%0d instr=%h want 1/0", q_count, instruction); end
        halt_clr = 1'b1;
        @(negedge clk);
        halt_clr = 1'b0;
        n_checks++; if ({err, q_count, busy} !== {1'b0, 4'd0, 1'b0}) begin n_fail++; $display("FAIL timeout_clear: err=%b cnt=%0d busy=%b want 0/0/0", err, q_count, busy); end
        exp_issued += 1; exp_stall += TO;
    endtask

    task automatic test_halt_vs_complete();
        int active_n = 0;
        wr_valid = 1'b1; wr_instr = W_FADD;
        @(negedge clk);
        wr_valid = 1'b0;
        for (int c = 0; c < 20 && active_n < 3; c++) begin
            @(negedge clk);
            if (fpu_active) active_n++;
        end
        n_checks++; if (active_n != 3) begin n_fail++; $display("FAIL hvc_start: got %0d active cycles want 3", active_n); end
        halt_req = 1'b1; fpu_complete = 1'b1;
        @(negedge clk);
        halt_req = 1'b0; fpu_complete = 1'b0;
        n_checks++; if ({instruction, fpu_active, busy} !== {32'h0, 1'b0, 1'b1}) begin n_fail++; $display("FAIL hvc_halt: instr=%h fa=%b busy=%b want 0/0/1", instruction, fpu_active, busy); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hvc_no_drain: busy=%b want 1 (still halted)", busy); end
        halt_clr = 1'b1;
        @(negedge clk);
        halt_clr = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hvc_clear: busy=%b want 0", busy); end
        exp_issued += 1; exp_stall += 2;
    endtask

    task automatic test_rst_flush();
        int active_n = 0;
        wr_valid = 1'b1; wr_instr = W_FADD;
        @(negedge clk);
        wr_valid = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (fpu_active) active_n++;
            else if (active_n > 0) break;
            wr_valid     = (active_n >= 1 && active_n <= 4);
            wr_instr     = (active_n == 1) ? W_RST : rand_word(c % 3);
            fpu_complete = (active_n == 6);
        end
        wr_valid = 1'b0; fpu_complete = 1'b0;
        n_checks++; if (q_count !== 4'd4) begin n_fail++; $display("FAIL rst_preload: cnt=%0d want 4", q_count); end
        @(negedge clk);
        @(negedge clk);
        n_checks++; if ({instruction, q_count, activation_signal} !== {W_RST, 4'd3, 1'b0}) begin n_fail++; $display("FAIL rst_issue: instr=%h cnt=%0d act=%b want %h/3/0", instruction, q_count, activation_signal, W_RST); end
        wr_valid = 1'b1; wr_instr = W_ADDI;
        @(negedge clk);
        wr_valid = 1'b0;
        n_checks++; if ({q_count, instruction} !== {4'd0, 32'h0}) begin n_fail++; $display("FAIL rst_flushed: cnt=%0d instr=%h want 0/0", q_count, instruction); end
        @(negedge clk);
        n_checks++; if ({busy, q_count} !== {1'b0, 4'd0}) begin n_fail++; $display("FAIL rst_idle: busy=%b cnt=%0d want 0/0", busy, q_count); end
        exp_issued += 2; exp_stall += 5;
    endtask

    // Reference model: each instruction expands into its per-cycle output
    // timeline (IDLE slot, issue slot(s), optional writeback bubble).
    task automatic test_random_stream();
        logic [31:0] words[$];
        logic [31:0] t_i[$];
        bit t_fa[$], t_act[$], t_cpl[$];
        int n, c, lat;
        logic [31:0] w;
        for (int b = 0; b < 8; b++) begin
            words.delete(); t_i.delete(); t_fa.delete(); t_act.delete(); t_cpl.delete();
            n = $urandom_range(1, DEPTH);
            for (int k = 0; k < n; k++) begin
                c = $urandom_range(0, 4);
                w = rand_word(c);
                words.push_back(w);
                t_i.push_back(32'h0); t_fa.push_back(0); t_act.push_back(0); t_cpl.push_back(0);
                if (c == 4) begin
                    lat = $urandom_range(1, 6);
                    for (int j = 0; j <= lat; j++) begin
                        t_i.push_back(w); t_fa.push_back(1); t_act.push_back(0); t_cpl.push_back(j == lat);
                    end
                    t_i.push_back(32'h0); t_fa.push_back(0); t_act.push_back(0); t_cpl.push_back(0);
                    exp_stall += lat;
                end else begin
                    t_i.push_back(w); t_fa.push_back(0); t_act.push_back(c <= 1); t_cpl.push_back(0);
                    if (c == 3) begin
                        t_i.push_back(32'h0); t_fa.push_back(0); t_act.push_back(0); t_cpl.push_back(0);
                    end
                end
            end
            exp_issued += n;
            wr_valid = 1'b1; wr_instr = words[0];
            for (int i = 0; i < t_i.size(); i++) begin
                @(negedge clk);
                n_checks++;
                if ({instruction, fpu_active, activation_signal} !== {t_i[i], t_fa[i], t_act[i]}) begin
                    n_fail++;
                    $display("FAIL stream b%0d c%0d: got %h fa=%b act=%b want %h fa=%b act=%b", b, i, instruction, fpu_active, activation_signal, t_i[i], t_fa[i], t_act[i]);
                end
                if (i + 1 < n) wr_instr = words[i + 1];
                else wr_valid = 1'b0;
                fpu_complete = t_cpl[i];
            end
            fpu_complete = 1'b0;
            @(negedge clk);
            n_checks++; if ({busy, q_count, instruction} !== {1'b0, 4'd0, 32'h0}) begin n_fail++; $display("FAIL stream_end b%0d: busy=%b cnt=%0d instr=%h want 0/0/0", b, busy, q_count, instruction); end
        end
    endtask

    task automatic test_perf_counters();
        int unsigned want_i, want_s;
`ifdef FPU_ISSUE_PERF_CNT_EN
        want_i = exp_issued; want_s = exp_stall;
`else
        want_i = 0; want_s = 0;
`endif
        n_checks++; if (perf_issued !== want_i) begin n_fail++; $display("FAIL perf_issued: got %0d want %0d", perf_issued, want_i); end
        n_checks++; if (perf_stall !== want_s) begin n_fail++; $display("FAIL perf_stall: got %0d want %0d", perf_stall, want_s); end
    endtask

    task automatic test_reset_midop();
        wr_valid = 1'b1; wr_instr = W_FADD;
        @(negedge clk);
        wr_instr = W_ADDI;
        @(negedge clk);
        wr_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({fpu_active, q_count} !== {1'b1, 4'd1}) begin n_fail++; $display("FAIL midop_pre: fa=%b cnt=%0d want 1/1", fpu_active, q_count); end
        rst_l = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
        n_checks++; if ({instruction, fpu_active, busy, q_count, err} !== {32'h0, 1'b0, 1'b0, 4'd0, 1'b0}) begin n_fail++; $display("FAIL midop_reset: instr=%h fa=%b busy=%b cnt=%0d err=%b want all 0", instruction, fpu_active, busy, q_count, err); end
        n_checks++; if ({perf_issued, perf_stall} !== 64'h0) begin n_fail++; $display("FAIL midop_perf: got %0d/%0d want 0/0", perf_issued, perf_stall); end
        repeat (2) @(negedge clk);
        n_checks++; if ({busy, fpu_active, instruction} !== {1'b0, 1'b0, 32'h0}) begin n_fail++; $display("FAIL midop_after: busy=%b fa=%b instr=%h want 0/0/0", busy, fpu_active, instruction); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_addi();
        test_fadd();
        test_full();
        test_timeout();
        test_halt_vs_complete();
        test_rst_flush();
        test_random_stream();
        test_perf_counters();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
